// File: rtl/vga_timing_gen.sv
// Parametrised progressive raster timing generator: sync, display enable, letterbox window,
// clamped window coordinates and line/frame strobes, all advancing on the pixel strobe only.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int WIN_X0   = 0,
    parameter int WIN_W    = 640,
    parameter int WIN_Y0   = 60,
    parameter int WIN_H    = 360,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int FRAME_W  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_stb,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de,
    output logic               o_win,
    output logic [XW-1:0]      o_x,
    output logic [YW-1:0]      o_y,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic               o_win_end,
    output logic [FRAME_W-1:0] o_frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] WX_BEG = HW'(WIN_X0);
    localparam logic [HW-1:0] WX_END = HW'(WIN_X0 + WIN_W);

    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] WY_BEG  = VW'(WIN_Y0);
    localparam logic [VW-1:0] WY_END  = VW'(WIN_Y0 + WIN_H);
    localparam logic [VW-1:0] WY_LAST = VW'(WIN_Y0 + WIN_H - 1);

    if (WIN_X0 + WIN_W > H_ACTIVE || WIN_Y0 + WIN_H > V_ACTIVE ||
        H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
        $error("vga_timing_gen: illegal timing or window parameters");
    end

    logic [HW-1:0] h, h_next;
    logic [VW-1:0] v, v_next;
    logic          hs_act, vs_act, de_next, win_next, frame_entry;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;

    always_comb begin
        h_next = h;
        v_next = v;
        if (i_pix_stb) begin
            if (h == H_LAST) begin
                h_next = '0;
                v_next = (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h_next = h + 1'b1;
            end
        end
    end

    // Decodes look at the position the counters are about to hold, so the registered
    // outputs line up with the counters rather than trailing them by a pixel.
    always_comb begin
        hs_act      = (h_next >= HS_BEG) && (h_next < HS_END);
        vs_act      = (v_next >= VS_BEG) && (v_next < VS_END);
        de_next     = (h_next < H_ACT) && (v_next < V_ACT);
        win_next    = (h_next >= WX_BEG) && (h_next < WX_END) &&
                      (v_next >= WY_BEG) && (v_next < WY_END);
        frame_entry = (h_next == '0) && (v_next == '0);
        if (h_next < WX_BEG)
            x_next = '0;
        else if (h_next >= WX_END)
            x_next = XW'(WIN_W - 1);
        else
            x_next = XW'(h_next - WX_BEG);
        if (v_next < WY_BEG)
            y_next = '0;
        else if (v_next >= WY_END)
            y_next = YW'(WIN_H - 1);
        else
            y_next = YW'(v_next - WY_BEG);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h             <= H_LAST;
            v             <= V_LAST;
            o_hs          <= ~HS_POL;
            o_vs          <= ~VS_POL;
            o_de          <= 1'b0;
            o_win         <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_win_end     <= 1'b0;
            o_frame_cnt   <= '1;
        end else begin
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_win_end     <= 1'b0;
            if (i_pix_stb) begin
                h             <= h_next;
                v             <= v_next;
                o_hs          <= hs_act ? HS_POL : ~HS_POL;
                o_vs          <= vs_act ? VS_POL : ~VS_POL;
                o_de          <= de_next;
                o_win         <= win_next;
                o_x           <= x_next;
                o_y           <= y_next;
                o_line_start  <= (h_next == '0);
                o_frame_start <= frame_entry;
                o_win_end     <= (h_next == H_LAST) && (v_next == WY_LAST);
                if (frame_entry)
                    o_frame_cnt <= o_frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (two small modes, one default mode)
// are driven together and compared every clock against a behavioural raster model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hsy, hbp, va, vfp, vsy, vbp;
        bit hpol, vpol;
        int wx0, ww, wy0, wh, fw;
    } cfg_t;

    typedef struct {
        int hs, vs, de, win, x, y, ls, fs, we, fc;
    } exp_t;

    typedef struct {
        int   h, v, fc;
        exp_t o;
    } mdl_t;

    localparam cfg_t CFG_A = '{ha:40, hfp:3, hsy:6, hbp:5, va:24, vfp:2, vsy:2, vbp:3,
                               hpol:1'b0, vpol:1'b0, wx0:0, ww:40, wy0:4, wh:16, fw:2};
    localparam cfg_t CFG_B = '{ha:32, hfp:2, hsy:4, hbp:4, va:20, vfp:1, vsy:3, vbp:2,
                               hpol:1'b1, vpol:1'b1, wx0:5, ww:20, wy0:3, wh:12, fw:3};
    localparam cfg_t CFG_C = '{ha:640, hfp:16, hsy:96, hbp:48, va:480, vfp:10, vsy:2, vbp:33,
                               hpol:1'b0, vpol:1'b0, wx0:0, ww:640, wy0:60, wh:360, fw:8};

    logic clk = 1'b0;
    logic i_rst = 1'b0;
    logic i_pix_stb = 1'b0;

    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_de, a_win, a_ls, a_fs, a_we;
    logic [5:0] a_x;
    logic [4:0] a_y;
    logic [1:0] a_fc;
    logic       b_hs, b_vs, b_de, b_win, b_ls, b_fs, b_we;
    logic [4:0] b_x;
    logic [3:0] b_y;
    logic [2:0] b_fc;
    logic       c_hs, c_vs, c_de, c_win, c_ls, c_fs, c_we;
    logic [9:0] c_x;
    logic [8:0] c_y;
    logic [7:0] c_fc;

    vga_timing_gen #(
        .H_ACTIVE(40), .H_FP(3), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .WIN_X0(0), .WIN_W(40), .WIN_Y0(4), .WIN_H(16),
        .XW(6), .YW(5), .FRAME_W(2)
    ) dut_a (
        .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
        .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de), .o_win(a_win), .o_x(a_x), .o_y(a_y),
        .o_line_start(a_ls), .o_frame_start(a_fs), .o_win_end(a_we), .o_frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(4),
        .V_ACTIVE(20), .V_FP(1), .V_SYNC(3), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .WIN_X0(5), .WIN_W(20), .WIN_Y0(3), .WIN_H(12),
        .XW(5), .YW(4), .FRAME_W(3)
    ) dut_b (
        .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
        .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de), .o_win(b_win), .o_x(b_x), .o_y(b_y),
        .o_line_start(b_ls), .o_frame_start(b_fs), .o_win_end(b_we), .o_frame_cnt(b_fc)
    );

    vga_timing_gen dut_c (
        .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
        .o_hs(c_hs), .o_vs(c_vs), .o_de(c_de), .o_win(c_win), .o_x(c_x), .o_y(c_y),
        .o_line_start(c_ls), .o_frame_start(c_fs), .o_win_end(c_we), .o_frame_cnt(c_fc)
    );

    int   n_checks = 0;
    int   n_fails  = 0;
    mdl_t m_a, m_b, m_c;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // Behavioural raster: walks h/v by the mode totals and rebuilds every output from scratch.
    function automatic mdl_t stepModel(cfg_t c, mdl_t m, bit rst, bit stb);
        mdl_t n;
        int   ht, vt, hs0, vs0;
        ht  = c.ha + c.hfp + c.hsy + c.hbp;
        vt  = c.va + c.vfp + c.vsy + c.vbp;
        hs0 = c.ha + c.hfp;
        vs0 = c.va + c.vfp;
        n = m;
        n.o.ls = 0;
        n.o.fs = 0;
        n.o.we = 0;
        if (rst) begin
            n.h = ht - 1;
            n.v = vt - 1;
            n.fc = (1 << c.fw) - 1;
            n.o.hs = c.hpol ? 0 : 1;
            n.o.vs = c.vpol ? 0 : 1;
            n.o.de = 0;
            n.o.win = 0;
            n.o.x = 0;
            n.o.y = 0;
        end else if (stb) begin
            if (m.h == ht - 1) begin
                n.h = 0;
                n.v = (m.v == vt - 1) ? 0 : m.v + 1;
            end else begin
                n.h = m.h + 1;
            end
            n.o.ls = (n.h == 0) ? 1 : 0;
            n.o.fs = (n.h == 0 && n.v == 0) ? 1 : 0;
            if (n.o.fs == 1)
                n.fc = (m.fc + 1) % (1 << c.fw);
            n.o.hs  = ((n.h >= hs0 && n.h < hs0 + c.hsy) == c.hpol) ? 1 : 0;
            n.o.vs  = ((n.v >= vs0 && n.v < vs0 + c.vsy) == c.vpol) ? 1 : 0;
            n.o.de  = (n.h < c.ha && n.v < c.va) ? 1 : 0;
            n.o.win = (n.h >= c.wx0 && n.h < c.wx0 + c.ww &&
                       n.v >= c.wy0 && n.v < c.wy0 + c.wh) ? 1 : 0;
            n.o.x   = (n.h < c.wx0) ? 0 : (n.h >= c.wx0 + c.ww) ? c.ww - 1 : n.h - c.wx0;
            n.o.y   = (n.v < c.wy0) ? 0 : (n.v >= c.wy0 + c.wh) ? c.wh - 1 : n.v - c.wy0;
            n.o.we  = (n.h == ht - 1 && n.v == c.wy0 + c.wh - 1) ? 1 : 0;
        end
        n.o.fc = n.fc;
        return n;
    endfunction

    task automatic checkOutput(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, want);
        end
    endtask

    task automatic checkDut(input string name, input exp_t got, input exp_t want);
        checkOutput({name, ".hs"},          got.hs,  want.hs);
        checkOutput({name, ".vs"},          got.vs,  want.vs);
        checkOutput({name, ".de"},          got.de,  want.de);
        checkOutput({name, ".win"},         got.win, want.win);
        checkOutput({name, ".x"},           got.x,   want.x);
        checkOutput({name, ".y"},           got.y,   want.y);
        checkOutput({name, ".line_start"},  got.ls,  want.ls);
        checkOutput({name, ".frame_start"}, got.fs,  want.fs);
        checkOutput({name, ".win_end"},     got.we,  want.we);
        checkOutput({name, ".frame_cnt"},   got.fc,  want.fc);
    endtask

    // One clock: drive on the falling edge, queue the predictions, compare just after the rise.
    task automatic applyStimulus(input bit rst, input bit stb);
        exp_t g;
        @(negedge clk);
        i_rst     = rst;
        i_pix_stb = stb;
        m_a = stepModel(CFG_A, m_a, rst, stb);
        m_b = stepModel(CFG_B, m_b, rst, stb);
        m_c = stepModel(CFG_C, m_c, rst, stb);
        q_a.push_back(m_a.o);
        q_b.push_back(m_b.o);
        q_c.push_back(m_c.o);
        @(posedge clk);
        #1;
        g = '{hs:int'(a_hs), vs:int'(a_vs), de:int'(a_de), win:int'(a_win), x:int'(a_x),
              y:int'(a_y), ls:int'(a_ls), fs:int'(a_fs), we:int'(a_we), fc:int'(a_fc)};
        checkDut("A", g, q_a.pop_front());
        g = '{hs:int'(b_hs), vs:int'(b_vs), de:int'(b_de), win:int'(b_win), x:int'(b_x),
              y:int'(b_y), ls:int'(b_ls), fs:int'(b_fs), we:int'(b_we), fc:int'(b_fc)};
        checkDut("B", g, q_b.pop_front());
        g = '{hs:int'(c_hs), vs:int'(c_vs), de:int'(c_de), win:int'(c_win), x:int'(c_x),
              y:int'(c_y), ls:int'(c_ls), fs:int'(c_fs), we:int'(c_we), fc:int'(c_fc)};
        checkDut("C", g, q_c.pop_front());
    endtask

    initial begin
        m_a = '{h:0, v:0, fc:0, o:'{default:0}};
        m_b = m_a;
        m_c = m_a;

        $display("[TB] reset, then idle cycles holding reset values");
        repeat (3) applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);

        $display("[TB] strobe every clock across several frames of the small modes");
        repeat (3500) applyStimulus(1'b0, 1'b1);

        $display("[TB] strobe every 4th clock");
        for (int i = 0; i < 700; i++)
            applyStimulus(1'b0, (i % 4) == 3);

        $display("[TB] random strobes");
        for (int i = 0; i < 600; i++)
            applyStimulus(1'b0, $urandom_range(0, 2) == 0);

        $display("[TB] mid-frame reset with a coincident strobe, then restart");
        applyStimulus(1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0);
        repeat (6800) applyStimulus(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator: the successor to the fixed 640x480 / 640x360-letterbox generator. It produces sync, display-enable, letterbox-window flags, window-relative pixel coordinates, and per-line and per-frame strobes for any progressive VGA-class mode. It sits between the pixel-strobe divider and the game renderer and framebuffer readers. All outputs are registered and advance only on pixel-strobe cycles.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low)
- WIN_X0 / WIN_W, 0 / 640, window horizontal origin / width within active area
- WIN_Y0 / WIN_H, 60 / 360, window vertical origin / height within active area
- XW / YW, 10 / 9, width of o_x / o_y
- FRAME_W, 8, frame counter width
- i_clk  in  1  base clock
- i_rst  in  1  reset; synchronous, active-high
- i_pix_stb  in  1  pixel strobe, one i_clk cycle wide
- o_hs  out  1  horizontal sync, level per HS_POL
- o_vs  out  1  vertical sync, level per VS_POL
- o_de  out  1  inside the full active area
- o_win  out  1  inside the letterbox window (subset of o_de)
- o_x  out  XW  window-relative x, clamped
- o_y  out  YW  window-relative y, clamped
- o_line_start  out  1  pulse on entering h=0
- o_frame_start  out  1  pulse on entering (h=0, v=0)
- o_win_end  out  1  pulse on the last pixel of the last window line
- o_frame_cnt  out  FRAME_W  frame count, wraps modulo 2^FRAME_W

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL likewise (default 525).
- Line layout is active, then FP, then sync, then BP. h in [0,H_ACTIVE) is active. Sync spans h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) (default 656..751). Vertical uses the same layout (default vs on v = 490..491).
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) advance on i_pix_stb only:
  - h wraps H_TOTAL-1 -> 0 and increments v.
  - v wraps V_TOTAL-1 -> 0 on that same strobe.
  - No off-by-one: exactly H_TOTAL strobes per line and V_TOTAL lines per frame.
- All level outputs are registered decodes of the counter position. The implementation decodes from the next-state counters, so each output describes the pixel the counters currently hold.
- o_de = (h < H_ACTIVE) and (v < V_ACTIVE).
- o_win = h in [WIN_X0, WIN_X0+WIN_W) and v in [WIN_Y0, WIN_Y0+WIN_H).
- o_x:
  - 0 when h < WIN_X0.
  - WIN_W-1 when h >= WIN_X0+WIN_W.
  - otherwise h-WIN_X0.
- o_y uses the same rule against WIN_Y0 / WIN_H.
- Pulses (o_line_start, o_frame_start, o_win_end):
  - High for exactly one i_clk cycle, the cycle after the strobe edge that entered the qualifying position.
  - Cleared on the next clock whether or not a strobe is present.
- o_win_end qualifies at h = H_TOTAL-1, v = WIN_Y0+WIN_H-1 (default v=419). This is the renderer's animate tick.
- o_frame_cnt increments on every transition into (0,0).
- Legal parameters: WIN_X0+WIN_W <= H_ACTIVE, WIN_Y0+WIN_H <= V_ACTIVE, and all porch/sync values >= 1. Anything else is illegal. An elaboration-time check fails the build on illegal values.

## Timing
- Reset (i_rst=1 on a clock edge) overrides i_pix_stb and sets:
  - h = H_TOTAL-1, v = V_TOTAL-1 (last blanking pixel).
  - o_hs = ~HS_POL, o_vs = ~VS_POL.
  - o_de=0, o_win=0, o_x=0, o_y=0.
  - all pulses 0.
  - o_frame_cnt = all ones.
- First strobe after reset enters (0,0):
  - o_frame_start and o_line_start pulse.
  - o_frame_cnt becomes 0.
  - o_de=1.
  - o_win per window (default 0, since WIN_Y0=60).
- Latency: outputs change on the same edge the counters advance, one i_clk after i_pix_stb is sampled. No output changes on non-strobe cycles except pulse clearing.
- Reset mid-frame takes effect on that edge, with no partial pulse. The following strobe restarts at (0,0) as above.
- Simultaneous h and v wrap produces a single transition. o_line_start, o_frame_start and the frame_cnt increment all occur on that one edge.
- o_frame_cnt wraps 2^FRAME_W-1 -> 0 silently.

## Test plan
- Reset then strobe every cycle with defaults -> o_frame_start at strobe 1 and again at strobe 420001. o_line_start every 800 strobes. o_frame_cnt 0 then 1.
- Defaults, one line at v=100 -> o_hs low for exactly 96 strobes starting at h=656. o_de high for 640 strobes. o_x runs 0..639. o_y = 40.
- Defaults, full frame -> o_vs low on lines 490–491 only. o_win high on lines 60..419. o_y clamps to 0 for v<60 and to 359 for v>=420. o_win_end fires once, at h=799, v=419.
- Strobe every 4th i_clk -> counters and levels hold between strobes. Each pulse is exactly one i_clk wide. Line period is 3200 clocks.
- Assert i_rst at v=200, h=300 -> reset values appear next edge. The next strobe gives o_frame_start, o_frame_cnt=0, h=v=0.
- HS_POL=1, VS_POL=1, H_ACTIVE=320, WIN_X0=40, WIN_W=240 -> o_hs high during sync. o_x=0 for h<40, then 0..239, and 239 for h>=280.
